// File: rtl/gppcu_issue_ctrl.sv
// gppcu_issue_ctrl
//   In-order issue controller. An instruction queue feeds a decode stage,
//   which issues into execute and then writeback. A per-register pending
//   scoreboard blocks any instruction that reads or writes a register with
//   a write still in flight.
//
//   Optional feature macro: GPPCU_ISSUE_BYPASS_EN
//     defined   -> the hazard check sees this cycle's writeback clear, so a
//                  dependent instruction issues in the producer's WB cycle
//     undefined -> the hazard check uses the registered scoreboard only
//
// Ports
//   iACLK                   clock, rising edge
//   iRST                    synchronous active-high reset
//   iINSTR/iUSE_RA/iUSE_RB/iWR_RD, iINSTR_VALID, oINSTR_READY  producer side
//   iBUSY                   multi-cycle unit holds the execute stage
//   iFLUSH                  drop queue and decode contents
//   oDEC_*/oEXE_*/oWB_*     stage contents
//   oSTALL                  decode holds a valid instruction that does not issue
//   oLEVEL                  queue occupancy
//   oSTALL_CNT              saturating stall-cycle counter
module gppcu_issue_ctrl #(
  parameter int IW     = 32,
  parameter int RBW    = 5,
  parameter int QDEPTH = 4,
  parameter int RD_LSB = 22,
  parameter int RA_LSB = 17,
  parameter int RB_LSB = 0
) (
  input  logic                      iACLK,
  input  logic                      iRST,
  input  logic [IW-1:0]             iINSTR,
  input  logic                      iUSE_RA,
  input  logic                      iUSE_RB,
  input  logic                      iWR_RD,
  input  logic                      iINSTR_VALID,
  output logic                      oINSTR_READY,
  input  logic                      iBUSY,
  input  logic                      iFLUSH,
  output logic                      oDEC_VALID,
  output logic [IW-1:0]             oDEC_INSTR,
  output logic                      oEXE_VALID,
  output logic [IW-1:0]             oEXE_INSTR,
  output logic                      oEXE_WR,
  output logic                      oWB_VALID,
  output logic [IW-1:0]             oWB_INSTR,
  output logic                      oWB_WR,
  output logic                      oSTALL,
  output logic [$clog2(QDEPTH):0]   oLEVEL,
  output logic [15:0]               oSTALL_CNT
);

  localparam int NUMREG = 2**RBW;
  localparam int PW     = $clog2(QDEPTH);
  localparam int EW     = IW + 3;
  localparam logic [PW:0] LVL_FULL = (PW+1)'(QDEPTH);

  logic [EW-1:0]     qMem [QDEPTH];
  logic [PW-1:0]     wrPtr, rdPtr;
  logic [PW:0]       level;
  logic [EW-1:0]     head;
  logic              push, decLoad, issue, hazard;

  logic              decValid, decUseRA, decUseRB, decWrRD;
  logic [IW-1:0]     decInstr;
  logic              exeValid, exeWr;
  logic [IW-1:0]     exeInstr;
  logic              wbValid, wbWr;
  logic [IW-1:0]     wbInstr;

  logic [NUMREG-1:0] pend, pendChk, wbClr, issueSet;
  logic [RBW-1:0]    decRd, decRa, decRb, wbRd;
  logic [15:0]       stallCnt;

  assign oINSTR_READY = (level != LVL_FULL) & ~iFLUSH;
  assign push         = iINSTR_VALID & oINSTR_READY;
  assign head         = qMem[rdPtr];

  assign decRd = decInstr[RD_LSB +: RBW];
  assign decRa = decInstr[RA_LSB +: RBW];
  assign decRb = decInstr[RB_LSB +: RBW];
  assign wbRd  = wbInstr[RD_LSB +: RBW];

  assign wbClr    = (wbValid & wbWr)  ? (NUMREG'(1) << wbRd)  : '0;
  assign issueSet = (issue & decWrRD) ? (NUMREG'(1) << decRd) : '0;

`ifdef GPPCU_ISSUE_BYPASS_EN
  assign pendChk = pend & ~wbClr;
`else
  assign pendChk = pend;
`endif

  assign hazard  = (decUseRA & pendChk[decRa]) |
                   (decUseRB & pendChk[decRb]) |
                   (decWrRD  & pendChk[decRd]);
  assign issue   = decValid & ~hazard & ~iBUSY;
  // Decode refills from the queue whenever its current occupant leaves.
  assign decLoad = (level != '0) & (~decValid | issue);

  always_ff @(posedge iACLK) begin
    if (iRST) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      decValid <= 1'b0;
      exeValid <= 1'b0;
      wbValid  <= 1'b0;
      pend     <= '0;
      stallCnt <= '0;
    end else begin
      if (iFLUSH) begin
        wrPtr    <= '0;
        rdPtr    <= '0;
        level    <= '0;
        decValid <= 1'b0;
      end else begin
        if (push)    wrPtr <= wrPtr + 1'b1;
        if (decLoad) rdPtr <= rdPtr + 1'b1;
        unique case ({push, decLoad})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
        if (decLoad)    decValid <= 1'b1;
        else if (issue) decValid <= 1'b0;
      end
      // Execute and writeback keep running through a flush so in-flight
      // writes still retire and release their scoreboard bits.
      if (issue)       exeValid <= 1'b1;
      else if (!iBUSY) exeValid <= 1'b0;
      wbValid <= exeValid & ~iBUSY;
      // Set is applied after clear so a same-cycle set wins.
      pend <= (pend & ~wbClr) | issueSet;
      if (oSTALL && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
    end
  end

  always_ff @(posedge iACLK) begin
    if (push) qMem[wrPtr] <= {iINSTR, iUSE_RA, iUSE_RB, iWR_RD};
    if (decLoad) {decInstr, decUseRA, decUseRB, decWrRD} <= head;
    if (issue) begin
      exeInstr <= decInstr;
      exeWr    <= decWrRD;
    end
    if (!iBUSY) begin
      wbInstr <= exeInstr;
      wbWr    <= exeWr;
    end
  end

  assign oDEC_VALID = decValid;
  assign oDEC_INSTR = decInstr;
  assign oEXE_VALID = exeValid;
  assign oEXE_INSTR = exeInstr;
  assign oEXE_WR    = exeValid & exeWr;
  assign oWB_VALID  = wbValid;
  assign oWB_INSTR  = wbInstr;
  assign oWB_WR     = wbValid & wbWr;
  assign oSTALL     = decValid & (hazard | iBUSY);
  assign oLEVEL     = level;
  assign oSTALL_CNT = stallCnt;

endmodule

// File: tb/tb_gppcu_issue_ctrl.sv
module tb_gppcu_issue_ctrl;

  logic        iACLK = 1'b0;
  logic        iRST = 1'b1;
  logic [31:0] iINSTR = '0;
  logic        iUSE_RA = 1'b0, iUSE_RB = 1'b0, iWR_RD = 1'b0;
  logic        iINSTR_VALID = 1'b0;
  logic        oINSTR_READY;
  logic        iBUSY = 1'b0, iFLUSH = 1'b0;
  logic        oDEC_VALID, oEXE_VALID, oEXE_WR, oWB_VALID, oWB_WR, oSTALL;
  logic [31:0] oDEC_INSTR, oEXE_INSTR, oWB_INSTR;
  logic [2:0]  oLEVEL;
  logic [15:0] oSTALL_CNT;

`ifdef GPPCU_ISSUE_BYPASS_EN
  localparam int HAZ_STALL = 1;
`else
  localparam int HAZ_STALL = 2;
`endif

  gppcu_issue_ctrl dut (
    .iACLK(iACLK), .iRST(iRST), .iINSTR(iINSTR), .iUSE_RA(iUSE_RA),
    .iUSE_RB(iUSE_RB), .iWR_RD(iWR_RD), .iINSTR_VALID(iINSTR_VALID),
    .oINSTR_READY(oINSTR_READY), .iBUSY(iBUSY), .iFLUSH(iFLUSH),
    .oDEC_VALID(oDEC_VALID), .oDEC_INSTR(oDEC_INSTR),
    .oEXE_VALID(oEXE_VALID), .oEXE_INSTR(oEXE_INSTR), .oEXE_WR(oEXE_WR),
    .oWB_VALID(oWB_VALID), .oWB_INSTR(oWB_INSTR), .oWB_WR(oWB_WR),
    .oSTALL(oSTALL), .oLEVEL(oLEVEL), .oSTALL_CNT(oSTALL_CNT)
  );

  always #5 iACLK = ~iACLK;

  int cyc = 0;
  always @(posedge iACLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    logic        wr;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int nCmp = 0;
  int nErr = 0;
  logic [15:0] sc0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int ra, input int rb, input int tag);
    logic [31:0] w;
    w = '0;
    w[26:22] = rd[4:0];
    w[21:17] = ra[4:0];
    w[4:0]   = rb[4:0];
    w[16:5]  = tag[11:0];
    return w;
  endfunction

  // Writeback monitor: every oWB_VALID pops one expected instruction.
  always @(negedge iACLK) begin
    if (!iRST && oWB_VALID) begin
      if (sb.size() == 0) begin
        nCmp++;
        nErr++;
        $display("FAIL wb_unexpected: got %0h expected none", oWB_INSTR);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_instr", oWB_INSTR, e.instr);
        check("wb_wr", oWB_WR, e.wr);
        if (e.cyc >= 0) check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic sync();
    @(posedge iACLK);
    #1;
  endtask

  // Called just after a rising edge; returns just after the push edge.
  // lat = edges from push edge to the WB edge, -1 = don't care.
  task automatic offer(input logic [31:0] ins, input logic ra, input logic rb,
                       input logic wr, input int lat, input bit expect_wb);
    bit done;
    int t;
    done = 0;
    t = 0;
    iINSTR = ins; iUSE_RA = ra; iUSE_RB = rb; iWR_RD = wr;
    iINSTR_VALID = 1'b1;
    while (!done && t < 50) begin
      @(negedge iACLK);
      if (oINSTR_READY) begin
        done = 1;
        if (expect_wb) sb.push_back('{ins, wr, (lat >= 0) ? cyc + 1 + lat : -1});
      end
      @(posedge iACLK);
      #1;
      t++;
    end
    iINSTR_VALID = 1'b0;
    if (!done) begin
      nCmp++;
      nErr++;
      $display("FAIL offer_timeout: got not-ready expected accept for %0h", ins);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge iACLK);
      t++;
    end
    @(negedge iACLK);
    check(name, sb.size(), 0);
  endtask

  // Waits for a given instruction to reach execute, then raises iBUSY.
  task automatic busy_when_exe(input logic [31:0] ins, input string name);
    bit seen;
    int t;
    seen = 0;
    t = 0;
    while (!seen && t < 50) begin
      @(negedge iACLK);
      if (oEXE_VALID && oEXE_INSTR == ins) seen = 1;
      t++;
    end
    check(name, seen, 1);
    iBUSY = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    nErr++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    logic [31:0] a;
    logic [31:0] p;
    logic [31:0] w;

    repeat (2) @(posedge iACLK);
    #1 iRST = 1'b0;
    @(negedge iACLK);
    check("rst_level", oLEVEL, 0);
    check("rst_dec_valid", oDEC_VALID, 0);
    check("rst_exe_valid", oEXE_VALID, 0);
    check("rst_wb_valid", oWB_VALID, 0);
    check("rst_stall_cnt", oSTALL_CNT, 0);
    check("rst_ready", oINSTR_READY, 1);

    // Four independent writers back to back: WB 3 edges after each push edge.
    sync();
    for (int i = 0; i < 4; i++) offer(mk(i + 1, 0, 0, 16 + i), 0, 0, 1, 3, 1);
    drain("t1_drain");
    check("t1_stall_cnt", oSTALL_CNT, 0);

    // Writer of R3 followed by a reader of R3.
    sync();
    sc0 = oSTALL_CNT;
    offer(mk(3, 0, 0, 32), 0, 0, 1, 3, 1);
    offer(mk(10, 3, 0, 33), 1, 0, 0, 3 + HAZ_STALL, 1);
    drain("t2_drain");
    check("t2_stall_delta", oSTALL_CNT - sc0, HAZ_STALL);

    // Execute held busy for three cycles while the queue fills.
    sync();
    a = mk(11, 0, 0, 48);
    fork
      begin
        offer(a, 0, 0, 0, -1, 1);
        for (int i = 1; i < 7; i++) offer(mk(12 + i, 0, 0, 48 + i), 0, 0, 0, -1, 1);
      end
      begin
        busy_when_exe(a, "t3_exe_seen");
        sc0 = oSTALL_CNT;
        repeat (3) begin
          @(negedge iACLK);
          check("t3_exe_valid", oEXE_VALID, 1);
          check("t3_exe_instr", oEXE_INSTR, a);
          check("t3_wb_bubble", oWB_VALID, 0);
          check("t3_stall", oSTALL, 1);
        end
        check("t3_level_full", oLEVEL, 4);
        check("t3_ready_low", oINSTR_READY, 0);
        iBUSY = 1'b0;
      end
    join
    drain("t3_drain");
    check("t3_stall_delta", oSTALL_CNT - sc0, 3);

    // Flush with three queued entries while a writer of R7 sits in execute.
    sync();
    p = mk(7, 0, 0, 64);
    fork
      begin
        offer(p, 0, 0, 1, -1, 1);
        for (int i = 1; i < 5; i++) offer(mk(20 + i, 0, 0, 64 + i), 0, 0, 0, -1, 0);
      end
      busy_when_exe(p, "t4_exe_seen");
    join
    iINSTR = mk(25, 0, 0, 70);
    iINSTR_VALID = 1'b1;
    iFLUSH = 1'b1;
    @(negedge iACLK);
    check("t4_level_before", oLEVEL, 3);
    check("t4_ready_flush", oINSTR_READY, 0);
    sync();
    iFLUSH = 1'b0;
    iINSTR_VALID = 1'b0;
    @(negedge iACLK);
    check("t4_level_after", oLEVEL, 0);
    check("t4_dec_valid", oDEC_VALID, 0);
    check("t4_exe_kept", oEXE_INSTR, p);
    iBUSY = 1'b0;
    drain("t4_drain_p");
    sync();
    sc0 = oSTALL_CNT;
    offer(mk(8, 7, 0, 71), 1, 0, 0, 3, 1);
    drain("t4_drain_y");
    check("t4_stall_delta", oSTALL_CNT - sc0, 0);

    // Reset with a full queue and a pending write of R9.
    sync();
    w = mk(9, 0, 0, 80);
    fork
      begin
        offer(w, 0, 0, 1, -1, 0);
        for (int i = 1; i < 6; i++) offer(mk(14 + i, 0, 0, 80 + i), 0, 0, 0, -1, 0);
      end
      busy_when_exe(w, "t5_exe_seen");
    join
    @(negedge iACLK);
    check("t5_level_full", oLEVEL, 4);
    check("t5_pending_wr", oEXE_WR, 1);
    sb.delete();
    iRST = 1'b1;
    iFLUSH = 1'b1;
    iINSTR_VALID = 1'b1;
    sync();
    iRST = 1'b0;
    iFLUSH = 1'b0;
    iINSTR_VALID = 1'b0;
    iBUSY = 1'b0;
    @(negedge iACLK);
    check("t5_level", oLEVEL, 0);
    check("t5_dec_valid", oDEC_VALID, 0);
    check("t5_exe_valid", oEXE_VALID, 0);
    check("t5_exe_wr", oEXE_WR, 0);
    check("t5_wb_valid", oWB_VALID, 0);
    check("t5_wb_wr", oWB_WR, 0);
    check("t5_stall_cnt", oSTALL_CNT, 0);
    sync();
    offer(mk(2, 9, 9, 90), 1, 1, 0, 3, 1);
    drain("t5_drain");
    check("t5_no_stall", oSTALL_CNT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
